hit_window_counter: RTL

Downstream consumer of the circle-membership stage. It accepts one membership bit `z` per sample over the `dav_`/`rfd` handshake and counts inside-circle hits over a fixed window of `WINDOW` samples. At the end of each window it presents the hit count to the next stage over a second `dav_`/`rfd` handshake. The hit/total ratio feeds the Monte-Carlo area estimate.

---
 rtl/hwc_pkg.sv | 11 +
 rtl/hwc_counter.sv | 17 +
 rtl/hit_window_counter.sv | 106 ++++++++++
 3 files changed

// File: rtl/hwc_pkg.sv
// hwc_pkg: shared state encoding and default sizing for hit_window_counter.
package hwc_pkg;
    localparam int WINDOW_DEF = 256;
    localparam int CNT_W_DEF  = 9;
    typedef enum logic [1:0] {
        RX_WAIT  = 2'd0,
        RX_ACK   = 2'd1,
        TX_VALID = 2'd2,
        TX_ACK   = 2'd3
    } state_t;
endpackage

// File: rtl/hwc_counter.sv
// hwc_counter: CNT_W-bit up counter with synchronous clear and increment enable.
module hwc_counter #(
    parameter int CNT_W = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_q
);
    logic [CNT_W-1:0] r_q;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)      r_q <= '0;
        else if (i_clr) r_q <= '0;
        else if (i_en)  r_q <= r_q + 1'b1;
    assign o_q = r_q;
endmodule

// File: rtl/hit_window_counter.sv
// hit_window_counter: counts inside-circle hits per WINDOW samples, four-phase handshakes both sides.
// Define HWC_MISS_OUT_EN to add the registered misses output.
module hit_window_counter
    import hwc_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dav_,
    output logic             rfd,
    input  logic             z,
    output logic             dav_out_,
    input  logic             rfd_out,
    output logic [CNT_W-1:0] hits
`ifdef HWC_MISS_OUT_EN
   ,output logic [CNT_W-1:0] misses
`endif
);
    state_t           r_state, w_next;
    logic             r_rfd, w_rfd, r_dav_out_, w_dav_out_;
    logic             w_load, w_clr, w_smp_en, w_hit_en;
    logic [CNT_W-1:0] r_hits, w_hit_cnt, w_smp_cnt;

    hwc_counter #(.CNT_W(CNT_W)) u_hit (
        .i_clk(clock), .i_rst(reset), .i_clr(w_clr), .i_en(w_hit_en), .o_q(w_hit_cnt)
    );
    hwc_counter #(.CNT_W(CNT_W)) u_smp (
        .i_clk(clock), .i_rst(reset), .i_clr(w_clr), .i_en(w_smp_en), .o_q(w_smp_cnt)
    );

    // TX transitions also look at our own registered dav_out_ so no handshake phase is skipped
    always_comb begin
        w_next     = r_state;
        w_rfd      = r_rfd;
        w_dav_out_ = r_dav_out_;
        w_load     = 1'b0;
        w_clr      = 1'b0;
        w_smp_en   = 1'b0;
        w_hit_en   = 1'b0;
        case (r_state)
            RX_WAIT: begin
                w_rfd = 1'b1;
                if (!dav_) begin
                    w_rfd    = 1'b0;
                    w_smp_en = 1'b1;
                    w_hit_en = z;
                    w_next   = RX_ACK;
                end
            end
            RX_ACK: begin
                w_rfd = 1'b0;
                if (dav_) begin
                    w_load = w_smp_cnt == CNT_W'(WINDOW);
                    w_rfd  = !w_load;
                    w_next = w_load ? TX_VALID : RX_WAIT;
                end
            end
            TX_VALID: begin
                w_rfd      = 1'b0;
                w_dav_out_ = 1'b0;
                if (!r_dav_out_ && !rfd_out) w_next = TX_ACK;
            end
            TX_ACK: begin
                w_dav_out_ = 1'b1;
                if (r_dav_out_ && rfd_out) begin
                    w_clr  = 1'b1;
                    w_rfd  = 1'b1;
                    w_next = RX_WAIT;
                end
            end
            default: begin
                w_clr      = 1'b1;
                w_rfd      = 1'b1;
                w_dav_out_ = 1'b1;
                w_next     = RX_WAIT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            r_state    <= RX_WAIT;
            r_rfd      <= 1'b1;
            r_dav_out_ <= 1'b1;
            r_hits     <= '0;
        end else begin
            r_state    <= w_next;
            r_rfd      <= w_rfd;
            r_dav_out_ <= w_dav_out_;
            if (w_load) r_hits <= w_hit_cnt;
        end

`ifdef HWC_MISS_OUT_EN
    logic [CNT_W-1:0] r_misses;
    always_ff @(posedge clock or posedge reset)
        if (reset)       r_misses <= '0;
        else if (w_load) r_misses <= CNT_W'(WINDOW) - w_hit_cnt;
    assign misses = r_misses;
`endif

    assign rfd      = r_rfd;
    assign dav_out_ = r_dav_out_;
    assign hits     = r_hits;
endmodule
